// File: rtl/updown_counter_n_pkg.sv
// Shared constants and parameter helpers for the up/down mod-N counter family.
// Users import counter_pkg::* to get the mode constants and range helpers.
package counter_pkg;

    // End-of-range behaviour selectors for the SATURATE parameter.
    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    // Largest legal count value for a given modulus.
    function automatic longint max_count(input longint modulus);
        return modulus - 64'sd1;
    endfunction

    // WIDTH must be 2..32 and MODULUS must fit: 2 <= MODULUS <= 2**WIDTH.
    function automatic bit params_ok(input int width, input longint modulus);
        return (width >= 2) && (width <= 32) &&
               (modulus >= 64'sd2) &&
               (modulus <= (64'sd1 <<< width));
    endfunction

endpackage

// File: rtl/updown_counter_n_if.sv
// Control/status bundle of one updown_counter_n instance.
// master = the controlling logic, slave = the counter itself.
interface updown_counter_n_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_gray;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, clr, load, din,
        input  q, q_gray, tc, wrap
    );

    modport slave (
        input  en, up_dn, clr, load, din,
        output q, q_gray, tc, wrap
    );
endinterface

// File: rtl/updown_counter_n_bin2gray.sv
// Binary to reflected-Gray conversion, purely combinational.
// Also used when passing count values across clock domains.
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down mod-N counter with clear, load, wrap/saturate ends
// and cascade outputs (combinational tc, registered one-cycle wrap pulse).
module updown_counter_n
    import counter_pkg::*;
#(
    parameter int     WIDTH    = 4,
    parameter longint MODULUS  = 16,
    parameter bit     SATURATE = CNT_WRAP
) (
    input  logic               clk,
    input  logic               rst,
    updown_counter_n_if.slave  bus
);

    generate
        if (!params_ok(WIDTH, MODULUS)) begin : g_param_err
            $error("updown_counter_n: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(max_count(MODULUS));

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (q_reg == MAX_Q);
    assign at_zero = (q_reg == '0);

    // Priority: clr > load > en > hold (rst is handled by the register).
    // NOTE: every variable gets a default before the if-chain, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        q_next    = q_reg;
        wrap_next = 1'b0;
        if (bus.clr) begin
            q_next = '0;
        end else if (bus.load) begin
            q_next = (bus.din > MAX_Q) ? MAX_Q : bus.din;
        end else if (bus.en) begin
            if (bus.up_dn) begin
                if (at_max) begin
                    q_next    = (SATURATE == CNT_SAT) ? q_reg : '0;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_reg + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    q_next    = (SATURATE == CNT_SAT) ? q_reg : MAX_Q;
                    wrap_next = 1'b1;
                end else begin
                    q_next = q_reg - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg    <= '0;
            wrap_reg <= 1'b0;
        end else begin
            q_reg    <= q_next;
            wrap_reg <= wrap_next;
        end
    end

    // tc is deliberately ungated by clr/load so it can feed the next stage's en
    // in the same cycle; cascades treat clr/load as global.
    assign bus.tc = bus.en & ((bus.up_dn & at_max) | (~bus.up_dn & at_zero));

    assign bus.q    = q_reg;
    assign bus.wrap = wrap_reg;

    bin2gray #(
        .WIDTH (WIDTH)
    ) u_bin2gray (
        .bin  (q_reg),
        .gray (bus.q_gray)
    );

endmodule

// File: tb/tb_updown_counter_n.sv
// Directed bench for updown_counter_n: mod-10 wrap and saturate instances,
// clamp/priority cases, async reset and a two-stage decade cascade.
module tb_updown_counter_n;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    updown_counter_n_if #(.WIDTH(4)) m_if ();
    updown_counter_n_if #(.WIDTH(4)) s_if ();
    updown_counter_n_if #(.WIDTH(4)) lo_if ();
    updown_counter_n_if #(.WIDTH(4)) hi_if ();

    assign hi_if.en = lo_if.tc;

    updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_main (
        .clk (clk), .rst (rst), .bus (m_if)
    );
    updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_SAT)) u_sat (
        .clk (clk), .rst (rst), .bus (s_if)
    );
    updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_lo (
        .clk (clk), .rst (rst), .bus (lo_if)
    );
    updown_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(CNT_WRAP)) u_hi (
        .clk (clk), .rst (rst), .bus (hi_if)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] gray4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        rst = 1'b1;
        m_if.en = 0;  m_if.up_dn = 1;  m_if.clr = 0;  m_if.load = 0;  m_if.din = '0;
        s_if.en = 0;  s_if.up_dn = 1;  s_if.clr = 0;  s_if.load = 0;  s_if.din = '0;
        lo_if.en = 0; lo_if.up_dn = 1; lo_if.clr = 0; lo_if.load = 0; lo_if.din = '0;
        hi_if.up_dn = 1; hi_if.clr = 0; hi_if.load = 0; hi_if.din = '0;
        #1;

        // Reset state
        check("rst_q", m_if.q, 0);
        check("rst_wrap", m_if.wrap, 0);
        check("rst_gray", m_if.q_gray, 0);
        check("rst_tc", m_if.tc, 0);
        m_if.en = 1;
        tick();
        check("rst_hold_q", m_if.q, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1. Count up 12 clocks: 1..9, 0, 1, 2
        for (int k = 1; k <= 12; k++) begin
            check("up_tc", m_if.tc, ((k - 1) % 10 == 9));
            tick();
            check("up_q", m_if.q, k % 10);
            check("up_wrap", m_if.wrap, (k == 10));
            check("up_gray", m_if.q_gray, gray4(4'(k % 10)));
        end

        // 2. From 0 count down, wrapping to 9
        m_if.clr = 1;
        tick();
        check("clr_q", m_if.q, 0);
        check("clr_wrap", m_if.wrap, 0);
        m_if.clr = 0; m_if.up_dn = 0;
        #1;
        check("dn_tc_at0", m_if.tc, 1);
        tick();
        check("dn_q9", m_if.q, 9);
        check("dn_wrap", m_if.wrap, 1);
        check("dn_tc_at9", m_if.tc, 0);
        tick();
        check("dn_q8", m_if.q, 8);
        check("dn_wrap_clr", m_if.wrap, 0);
        tick();
        check("dn_q7", m_if.q, 7);

        // 3. Load clamp and priority
        m_if.load = 1; m_if.din = 13; m_if.en = 0;
        tick();
        check("load_clamp", m_if.q, 9);
        check("load_wrap", m_if.wrap, 0);
        m_if.din = 5; m_if.en = 1; m_if.up_dn = 1;
        tick();
        check("load_over_en", m_if.q, 5);
        m_if.clr = 1; m_if.din = 7;
        tick();
        check("clr_over_load", m_if.q, 0);
        m_if.clr = 0; m_if.din = 9; m_if.en = 0;
        tick();
        check("load9", m_if.q, 9);
        m_if.load = 0;
        #1;
        check("tc_gated_en", m_if.tc, 0);
        tick();
        check("hold_q", m_if.q, 9);
        check("hold_wrap", m_if.wrap, 0);

        // 4. Saturating instance
        s_if.load = 1; s_if.din = 7;
        tick();
        check("sat_load7", s_if.q, 7);
        s_if.load = 0; s_if.en = 1; s_if.up_dn = 1;
        tick();
        check("sat_q8", s_if.q, 8);
        tick();
        check("sat_q9", s_if.q, 9);
        check("sat_w0", s_if.wrap, 0);
        check("sat_tc", s_if.tc, 1);
        tick();
        check("sat_hold1", s_if.q, 9);
        check("sat_w1", s_if.wrap, 1);
        tick();
        check("sat_hold2", s_if.q, 9);
        check("sat_w2", s_if.wrap, 1);
        s_if.load = 1; s_if.din = 1;
        tick();
        check("sat_load1", s_if.q, 1);
        check("sat_load_w", s_if.wrap, 0);
        s_if.load = 0; s_if.up_dn = 0;
        tick();
        check("sat_dn0", s_if.q, 0);
        check("sat_dn_w0", s_if.wrap, 0);
        tick();
        check("sat_dn_hold", s_if.q, 0);
        check("sat_dn_w1", s_if.wrap, 1);
        s_if.en = 0;
        tick();
        check("sat_idle_w", s_if.wrap, 0);

        // 6. Decade cascade, 25 clocks
        check("cas_start_lo", lo_if.q, 0);
        check("cas_start_hi", hi_if.q, 0);
        lo_if.en = 1;
        for (int k = 1; k <= 25; k++) begin
            tick();
            check("cas_lo", lo_if.q, k % 10);
            check("cas_hi", hi_if.q, k / 10);
            check("cas_lo_gray", lo_if.q_gray, gray4(4'(k % 10)));
            check("cas_hi_gray", hi_if.q_gray, gray4(4'(k / 10)));
        end
        lo_if.en = 0;
        tick();
        check("cas_final", {24'd0, hi_if.q, lo_if.q}, 32'h25);

        // 5. Asynchronous reset mid-cycle at q=6
        m_if.load = 1; m_if.din = 6;
        tick();
        check("pre_rst_q6", m_if.q, 6);
        m_if.load = 0; m_if.en = 1; m_if.up_dn = 1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q", m_if.q, 0);
        check("async_rst_wrap", m_if.wrap, 0);
        check("async_rst_lo", lo_if.q, 0);
        check("async_rst_hi", hi_if.q, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("post_rst_q1", m_if.q, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
- Parametrised successor to the team's fixed 4-bit up counter.
- Adds configurable width and modulus, count direction, enable, synchronous clear and parallel load.
- Selects wrap or saturate at the ends of the count range, and provides cascade outputs (terminal count and a wrap pulse).
- Used standalone (decade or mod-N counting) or chained with other instances via `tc` to build wider counters.

Parameters:
- `WIDTH`, 4: counter register width in bits; legal range 2..32.
- `MODULUS`, 16: count range is 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH.
- `SATURATE`, 0: 0 = wrap at the range ends; 1 = hold at the range ends.

Ports:
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous active-high reset.
- `en`, input, 1: count enable.
- `up_dn`, input, 1: 1 = count up, 0 = count down.
- `clr`, input, 1: synchronous clear to 0.
- `load`, input, 1: synchronous parallel load.
- `din`, input, WIDTH: load value.
- `q`, output, WIDTH: registered count value.
- `q_gray`, output, WIDTH: Gray-coded form of `q` (combinational from `q`).
- `tc`, output, 1: combinational terminal count.
- `wrap`, output, 1: registered one-cycle wrap/saturation pulse.

Behaviour:
- Reset and clock
  - One clock, `clk`. Reset is asynchronous and active-high on `rst`.
  - While `rst` is high: `q` = 0, `wrap` = 0. `q_gray` and `tc` follow from `q` = 0.
  - Reset asserted mid-count clears `q` immediately, without waiting for a clock edge.
  - Counting resumes on the first rising edge after `rst` falls, provided `en` is high.
- Priority at each rising edge: `rst` > `clr` > `load` > `en` > hold.
- `clr`: `q` <= 0 and `wrap` <= 0. `en`, `load` and `up_dn` are ignored.
- `load`
  - `q` <= `din` if `din` <= MODULUS-1; otherwise `q` <= MODULUS-1 (clamp).
  - `wrap` <= 0. Load does not require `en`.
- Counting with `en` = 1
  - Up, q < MODULUS-1: q+1.
  - Down, q > 0: q-1.
  - Up, q = MODULUS-1: wrap mode goes to 0; saturate mode holds.
  - Down, q = 0: wrap mode goes to MODULUS-1; saturate mode holds.
  - `wrap` <= 1 for exactly the one cycle following an end-of-range event, in both modes.
- `en` = 0 with no clear or load: `q` holds and `wrap` <= 0.
- Latency: `q` updates one cycle after the controlling inputs are sampled. `wrap` is aligned with the new `q` value.
- `tc` = en & ((up_dn & q == MODULUS-1) | (~up_dn & q == 0)).
  - Combinational, so it can drive the next stage's `en` in the same cycle.
  - `tc` is not gated by `clr`/`load`. Cascades should treat `clr`/`load` as global.
- `q_gray` = q ^ (q >> 1), with no added latency.
- Width rules
  - Arithmetic is done in WIDTH bits. Comparisons use the constant MODULUS-1 sized to WIDTH.
  - No overflow past MODULUS-1 is possible.
- Direction change takes effect on the next enabled edge. There is no dead cycle.

Decomposition:
- Package `counter_pkg`:
  - mode constants `CNT_WRAP` = 0 and `CNT_SAT` = 1;
  - a function computing the max count from MODULUS;
  - the WIDTH/MODULUS legality check, which raises an elaboration-time error on violation.
- Sub-module `bin2gray`, parametrised by WIDTH, purely combinational. It is reused elsewhere for CDC of count values.

Test Plan (WIDTH=4, MODULUS=10, SATURATE=0 unless stated):
1. Reset, then `en`=1, `up_dn`=1 for 12 clocks:
   - `q` sequence is 1..9, 0, 1, 2.
   - `tc`=1 only while q=9.
   - `wrap`=1 only in the cycle q=0 follows q=9.
2. From q=0 with `up_dn`=0, `en`=1:
   - next q=9, with `wrap`=1 for one cycle.
   - Continue to 8, 7, ...
   - `tc`=1 while q=0.
3. `load`=1 with `din`=13:
   - q=9 (clamp).
   - `load`=1, `din`=5, `en`=1 in the same cycle: q=5, not 6.
   - `clr`+`load` together: q=0.
4. SATURATE=1:
   - Count up from 7: 8, 9, 9, 9.
   - `wrap` pulses on each held cycle.
   - Down from 1: 0, 0.
5. Assert `rst` asynchronously mid-cycle at q=6:
   - q=0 before the next edge.
   - Release `rst`: q=1 on the first enabled edge.
6. Cascade two instances, lower stage `tc` driving upper stage `en`, for 25 clocks:
   - Combined count is 25 decimal (upper=2, lower=5).
   - `q_gray` matches q^(q>>1) on every cycle.
